xalu_sequencer: RTL and testbench

Multi-cycle HI/LO unit and its sequencer for the pipelined MIPS core's execute stage. Accepts mult/multu/div/divu/mthi/mtlo commands from the E-stage control signals, holds the operation for a fixed latency with `Busy` raised, then commits the results to HI/LO. The hazard unit stalls HI/LO-dependent instructions on `Busy`. The exception controller suppresses a same-cycle launch via `HWClr`.

---
 rtl/xalu_sequencer_pkg.sv | 30 +++
 rtl/xalu_sequencer_result.sv | 75 +++++++
 rtl/xalu_sequencer.sv | 115 +++++++++++
 tb/tb_xalu_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_sequencer_pkg.sv
// Shared constants for the HI/LO multi-cycle unit: op encodings, latencies, FSM states.
// Define XALU_MADD_EN to implement the madd/maddu accumulate family.
package xalu_sequencer_pkg;

  localparam int XALUOP_SIZE = 3;

  localparam logic [XALUOP_SIZE-1:0] OP_MULT  = 3'b000;
  localparam logic [XALUOP_SIZE-1:0] OP_MULTU = 3'b001;
  localparam logic [XALUOP_SIZE-1:0] OP_DIV   = 3'b010;
  localparam logic [XALUOP_SIZE-1:0] OP_DIVU  = 3'b011;
  localparam logic [XALUOP_SIZE-1:0] OP_MTHI  = 3'b100;
  localparam logic [XALUOP_SIZE-1:0] OP_MTLO  = 3'b101;
  localparam logic [XALUOP_SIZE-1:0] OP_MADD  = 3'b110;
  localparam logic [XALUOP_SIZE-1:0] OP_MADDU = 3'b111;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

`ifdef XALU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } xalu_state_t;

endpackage

// File: rtl/xalu_sequencer_result.sv
// xalu_result: combinational next-{HI,LO} for a latched op; write-enable drops on divide-by-zero.
// The madd/maddu branch exists only when XALU_MADD_EN is defined.
module xalu_result
  import xalu_sequencer_pkg::*;
(
  input  logic [XALUOP_SIZE-1:0] op,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic [31:0]            hi,
  input  logic [31:0]            lo,
  output logic [63:0]            next_hilo,
  output logic                   we
);

  logic        mul_signed_s;
  logic        div_signed_s;
  logic [63:0] ext_a_s;
  logic [63:0] ext_b_s;
  logic [63:0] prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] safe_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Product modulo 2^64 of sign/zero-extended operands, and sign-magnitude division.
  always_comb begin
    mul_signed_s = (op == OP_MULT) || (op == OP_MADD);
    div_signed_s = (op == OP_DIV);
    ext_a_s  = mul_signed_s ? {{32{a[31]}}, a} : {32'h0000_0000, a};
    ext_b_s  = mul_signed_s ? {{32{b[31]}}, b} : {32'h0000_0000, b};
    prod_s   = ext_a_s * ext_b_s;
    a_neg_s  = div_signed_s & a[31];
    b_neg_s  = div_signed_s & b[31];
    mag_a_s  = a_neg_s ? (32'd0 - a) : a;
    mag_b_s  = b_neg_s ? (32'd0 - b) : b;
    // Substitute 1 for a zero divisor so the datapath stays defined; we masks the write.
    safe_b_s = (b == 32'd0) ? 32'd1 : mag_b_s;
    q_mag_s  = mag_a_s / safe_b_s;
    r_mag_s  = mag_a_s % safe_b_s;
    quot_s   = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Select the committed value for the latched op.
  always_comb begin
    next_hilo = {hi, lo};
    we        = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        next_hilo = prod_s;
        we        = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        next_hilo = {rem_s, quot_s};
        we        = (b != 32'd0);
      end
`ifdef XALU_MADD_EN
      OP_MADD, OP_MADDU: begin
        next_hilo = {hi, lo} + prod_s;
        we        = 1'b1;
      end
`endif
      default: begin
        next_hilo = {hi, lo};
        we        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/xalu_sequencer.sv
// HI/LO sequencer: accepts a command when idle, holds Busy for the op latency, then commits.
// Codes 110/111 launch only when XALU_MADD_EN is defined; otherwise they are no-ops.
module xalu_sequencer
  import xalu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [XALUOP_SIZE-1:0] XAluOp,
  input  logic                   HWClr,
  input  logic [31:0]            A,
  input  logic [31:0]            B,
  output logic                   Busy,
  output logic [31:0]            HI,
  output logic [31:0]            LO
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  xalu_state_t            state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [XALUOP_SIZE-1:0] op_r;
  logic [31:0]            a_r;
  logic [31:0]            b_r;
  logic                   busy_r;
  logic [31:0]            hi_r;
  logic [31:0]            lo_r;
  logic [63:0]            next_hilo_s;
  logic                   we_s;
  logic                   accept_s;
  logic                   launch_s;

  xalu_result u_result (
    .op        (op_r),
    .a         (a_r),
    .b         (b_r),
    .hi        (hi_r),
    .lo        (lo_r),
    .next_hilo (next_hilo_s),
    .we        (we_s)
  );

  // Acceptance qualification and whether the accepted code needs the multi-cycle path.
  always_comb begin
    accept_s = Start && !HWClr && (state_r == ST_IDLE);
    case (XAluOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: launch_s = 1'b1;
      OP_MADD, OP_MADDU:                  launch_s = MADD_EN;
      default:                            launch_s = 1'b0;
    endcase
  end

  // Sequencer FSM, down-counter, operand latches and HI/LO registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      op_r    <= OP_MULT;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && launch_s) begin
            op_r    <= XAluOp;
            a_r     <= A;
            b_r     <= B;
            cnt_r   <= ((XAluOp == OP_DIV) || (XAluOp == OP_DIVU)) ? DIV_LOAD : MULT_LOAD;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else if (accept_s && (XAluOp == OP_MTHI)) begin
            hi_r <= A;
          end else if (accept_s && (XAluOp == OP_MTLO)) begin
            lo_r <= A;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == '0) begin
            if (we_s) begin
              hi_r <= next_hilo_s[63:32];
              lo_r <= next_hilo_s[31:0];
            end else begin
              hi_r <= hi_r;
            end
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_xalu_sequencer.sv
// Self-checking bench for xalu_sequencer: behavioural HI/LO model, per-cycle compare, directed literals.
// Define XALU_MADD_EN to exercise the madd/maddu family.
module tb_xalu_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  XAluOp;
  logic        HWClr;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  xalu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .XAluOp(XAluOp),
    .HWClr (HWClr),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct packed {
    logic        wr;
    logic [63:0] res;
    int          lat;
  } mres_t;

  // Reference semantics: what a command does to {HI,LO}, computed with 64-bit integer arithmetic.
  function automatic mres_t model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hi, input logic [31:0] lo);
    mres_t r;
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r.wr  = 1'b1;
    r.lat = 0;
    r.res = {hi, lo};
    case (op)
      3'd0: begin r.res = 64'(sa * sb); r.lat = MC; end
      3'd1: begin r.res = ua * ub;      r.lat = MC; end
      3'd2: begin
        r.lat = DC;
        if (sb == 0) r.wr = 1'b0;
        else r.res = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        r.lat = DC;
        if (ub == 0) r.wr = 1'b0;
        else r.res = {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: r.res = {a, lo};
      3'd5: r.res = {hi, a};
`ifdef XALU_MADD_EN
      3'd6: begin r.res = {hi, lo} + 64'(sa * sb); r.lat = MC; end
      3'd7: begin r.res = {hi, lo} + ua * ub;      r.lat = MC; end
`else
      3'd6, 3'd7: r.wr = 1'b0;
`endif
      default: r.wr = 1'b0;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi, m_lo;
  int          m_rem;
  logic [63:0] m_res;
  logic        m_wr;
  mres_t       cur;

  always_comb cur = model_op(XAluOp, A, B, m_hi, m_lo);

  // Model: m_rem counts the remaining busy cycles; the result lands when it expires.
  always @(posedge Clock) begin
    if (Reset) begin
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
      m_rem <= 0;
      m_res <= 64'd0;
      m_wr  <= 1'b0;
    end else if (m_rem > 0) begin
      if (Start) begin
        n_fail <= n_fail + 1;
        $display("FAIL start_in_run: Start=%0b while busy, required 0", Start);
      end
      if (m_rem == 1 && m_wr) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
      m_rem <= m_rem - 1;
    end else if (Start && !HWClr) begin
      if (cur.lat == 0) begin
        if (cur.wr) begin
          m_hi <= cur.res[63:32];
          m_lo <= cur.res[31:0];
        end
      end else begin
        m_rem <= cur.lat;
        m_res <= cur.res;
        m_wr  <= cur.wr;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge Clock) begin
    if (chk_en) begin
      check("busy", {63'd0, Busy}, {63'd0, (m_rem > 0)});
      check("hi", {32'd0, HI}, {32'd0, m_hi});
      check("lo", {32'd0, LO}, {32'd0, m_lo});
    end
  end

  task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic clr);
    Start  = 1'b1;
    XAluOp = op;
    A      = a;
    B      = b;
    HWClr  = clr;
    @(posedge Clock); #1;
    Start = 1'b0;
    HWClr = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic run_lit(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    cmd(op, a, b, 1'b0);
    if (lat > 0) begin
      check({name, "_busy_first"}, {63'd0, Busy}, 64'd1);
      repeat (lat - 1) @(posedge Clock);
      #1;
      check({name, "_busy_last"}, {63'd0, Busy}, 64'd1);
      check({name, "_hi_hold"}, {32'd0, HI}, {32'd0, m_hi});
      @(posedge Clock); #1;
    end
    check({name, "_busy_done"}, {63'd0, Busy}, 64'd0);
    check({name, "_hi"}, {32'd0, HI}, {32'd0, ehi});
    check({name, "_lo"}, {32'd0, LO}, {32'd0, elo});
  endtask

  logic [31:0] specials [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0002};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    else return $urandom;
  endfunction

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    XAluOp = 3'd0;
    HWClr  = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    repeat (2) @(posedge Clock);
    #1;
    Reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    run_lit("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(posedge Clock); #1;
    run_lit("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge Clock); #1;
    run_lit("div", 3'd2, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(posedge Clock); #1;
    run_lit("divu_zero", 3'd3, 32'd7, 32'd0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(posedge Clock); #1;
    run_lit("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000);
    @(posedge Clock); #1;
    run_lit("divu", 3'd3, 32'd100, 32'd7, DC, 32'd2, 32'd14);
    // Flushed mthi must leave HI alone; the unflushed one lands in the next cycle.
    cmd(3'd4, 32'h1234_5678, 32'd0, 1'b1);
    check("mthi_flushed", {32'd0, HI}, {32'd0, 32'd2});
    run_lit("mthi", 3'd4, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd14);

    run_lit("mthi0", 3'd4, 32'd0, 32'd0, 0, 32'd0, 32'd14);
    run_lit("mtlo", 3'd5, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef XALU_MADD_EN
    run_lit("maddu", 3'd7, 32'd1, 32'd1, MC, 32'd1, 32'd0);
    @(posedge Clock); #1;
    run_lit("madd", 3'd6, 32'hFFFF_FFFF, 32'd2, MC, 32'd0, 32'hFFFF_FFFE);
`else
    run_lit("maddu_off", 3'd7, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif
    @(posedge Clock); #1;

    // Reset on the third busy cycle discards the in-flight mult.
    run_lit("mthi_pre", 3'd4, 32'hCAFE_F00D, 32'd0, 0, 32'hCAFE_F00D, LO);
    cmd(3'd0, 32'd9, 32'd9, 1'b0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    repeat (MC + 3) @(posedge Clock);
    #1;
    check("rst_no_commit", {HI, LO}, 64'd0);

    // Randomized traffic; commands only issued while the model is idle.
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if (m_rem == 0 && $urandom_range(0, 2) != 0) begin
        Start  = 1'b1;
        XAluOp = 3'($urandom_range(0, 7));
        HWClr  = ($urandom_range(0, 4) == 0);
      end else begin
        Start = 1'b0;
        HWClr = ($urandom_range(0, 4) == 0);
      end
      A = pick();
      B = pick();
      @(posedge Clock); #1;
    end
    Reset = 1'b0;
    Start = 1'b0;
    HWClr = 1'b0;
    repeat (DC + 2) @(posedge Clock);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
